ps2_mouse_decoder: RTL

Parametrised PS/2 mouse receiver that replaces the free-running PS2_CLK-domain capture with a fully CLK-synchronous design. It oversamples PS2_CLK/PS2_DATA and assembles 11-bit frames with start/parity/stop checking. Frames are collected into 3- or 4-byte packets with byte-0 resync and an inactivity watchdog. It outputs full 9-bit signed deltas, buttons, wheel, thresholded direction flags and a clamped cursor position for the VGA pipeline.

---
 rtl/ps2_mouse_decoder.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_mouse_decoder.sv
// CLK-synchronous PS/2 mouse receiver: oversampled frame capture, 3/4-byte packet
// assembly with resync and watchdog, delta/button/wheel decode and clamped cursor.
module ps2_mouse_decoder #(
    parameter int PACKET_BYTES   = 3,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int MOVE_THRESHOLD = 8,
    parameter int X_MAX          = 639,
    parameter int Y_MAX          = 479
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         PS2_CLK,
    input  logic                         PS2_DATA,
    output logic                         packet_valid,
    output logic                         frame_error,
    output logic                         left_click,
    output logic                         right_click,
    output logic                         middle_click,
    output logic [8:0]                   delta_x,
    output logic [8:0]                   delta_y,
    output logic [3:0]                   wheel,
    output logic                         mouse_up,
    output logic                         mouse_down,
    output logic                         mouse_left,
    output logic                         mouse_right,
    output logic [$clog2(X_MAX+1)-1:0]   cursor_x,
    output logic [$clog2(Y_MAX+1)-1:0]   cursor_y
);

    localparam int XW = $clog2(X_MAX + 1);
    localparam int YW = $clog2(Y_MAX + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0] LAST_IDX = 2'(PACKET_BYTES - 1);
    localparam logic signed [11:0] THR    = 12'(MOVE_THRESHOLD);
    localparam logic signed [11:0] XMAX_S = 12'(X_MAX);
    localparam logic signed [11:0] YMAX_S = 12'(Y_MAX);

    typedef enum logic [1:0] {ST_START, ST_DATA, ST_PARITY, ST_STOP} frame_state_t;

    logic [1:0]   clk_sync;
    logic [1:0]   data_sync;
    logic         clk_prev;
    logic         fall;
    logic         bit_in;

    frame_state_t state, state_next;
    logic [2:0]   bit_cnt, bit_cnt_next;
    logic [7:0]   shift, shift_next;
    logic         parity_ok, parity_next;
    logic [1:0]   byte_idx, idx_next;
    logic [WW-1:0] wd, wd_next;
    logic         busy;
    logic         err_next;
    logic         done, done_next;
    logic         store_en;

    logic [6:0]   hdr;
    logic [7:0]   b1;
    logic [7:0]   b2;
    logic [3:0]   b3;

    logic [8:0]   dx_new, dy_new;
    logic signed [11:0] dx_ext, dy_ext, cx_cur, cy_cur, cx_sum, cy_sum;
    logic [XW-1:0] cx_next;
    logic [YW-1:0] cy_next;
    logic [3:0]   wheel_new;

    // Synchronisers idle high so reset release never fakes a falling edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], PS2_CLK};
            data_sync <= {data_sync[0], PS2_DATA};
            clk_prev  <= clk_sync[1];
        end
    end

    assign fall   = clk_prev & ~clk_sync[1];
    assign bit_in = data_sync[1];
    assign busy   = (state != ST_START) || (byte_idx != 2'd0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_START;
            bit_cnt   <= 3'd0;
            shift     <= 8'd0;
            parity_ok <= 1'b0;
            byte_idx  <= 2'd0;
            wd        <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            bit_cnt   <= bit_cnt_next;
            shift     <= shift_next;
            parity_ok <= parity_next;
            byte_idx  <= idx_next;
            wd        <= wd_next;
            done      <= done_next;
        end
    end

    // An edge always wins over watchdog expiry and restarts the count.
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        shift_next   = shift;
        parity_next  = parity_ok;
        idx_next     = byte_idx;
        wd_next      = wd;
        err_next     = 1'b0;
        done_next    = 1'b0;
        store_en     = 1'b0;
        if (fall) begin
            wd_next = '0;
            unique case (state)
                ST_START: begin
                    if (!bit_in) begin
                        state_next   = ST_DATA;
                        bit_cnt_next = 3'd0;
                    end
                end
                ST_DATA: begin
                    shift_next   = {bit_in, shift[7:1]};
                    bit_cnt_next = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_next = ST_PARITY;
                end
                ST_PARITY: begin
                    parity_next = ^{shift, bit_in};
                    state_next  = ST_STOP;
                end
                ST_STOP: begin
                    state_next = ST_START;
                    if (!bit_in || !parity_ok) begin
                        err_next = 1'b1;
                        idx_next = 2'd0;
                    end else if (byte_idx == 2'd0 && !shift[3]) begin
                        err_next = 1'b1;
                    end else begin
                        store_en = 1'b1;
                        if (byte_idx == LAST_IDX) begin
                            idx_next  = 2'd0;
                            done_next = 1'b1;
                        end else begin
                            idx_next = byte_idx + 2'd1;
                        end
                    end
                end
            endcase
        end else if (busy) begin
            if (wd == WW'(TIMEOUT_CYCLES - 1)) begin
                err_next   = 1'b1;
                state_next = ST_START;
                idx_next   = 2'd0;
                wd_next    = '0;
            end else begin
                wd_next = wd + WW'(1);
            end
        end else begin
            wd_next = '0;
        end
    end

    // Byte 0 is kept without its always-one sync bit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hdr <= 7'd0;
            b1  <= 8'd0;
            b2  <= 8'd0;
            b3  <= 4'd0;
        end else if (store_en) begin
            case (byte_idx)
                2'd0:    hdr <= {shift[7:4], shift[2:0]};
                2'd1:    b1  <= shift;
                2'd2:    b2  <= shift;
                default: b3  <= shift[3:0];
            endcase
        end
    end

    always_comb begin
        dx_new    = hdr[5] ? (hdr[3] ? 9'h100 : 9'h0FF) : {hdr[3], b1};
        dy_new    = hdr[6] ? (hdr[4] ? 9'h100 : 9'h0FF) : {hdr[4], b2};
        dx_ext    = {{3{dx_new[8]}}, dx_new};
        dy_ext    = {{3{dy_new[8]}}, dy_new};
        cx_cur    = 12'(cursor_x);
        cy_cur    = 12'(cursor_y);
        cx_sum    = cx_cur + dx_ext;
        cy_sum    = cy_cur - dy_ext;
        cx_next   = (cx_sum < 12'sd0) ? '0 : (cx_sum > XMAX_S) ? XW'(X_MAX) : cx_sum[XW-1:0];
        cy_next   = (cy_sum < 12'sd0) ? '0 : (cy_sum > YMAX_S) ? YW'(Y_MAX) : cy_sum[YW-1:0];
        wheel_new = (PACKET_BYTES == 4) ? b3 : 4'd0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            packet_valid <= 1'b0;
            frame_error  <= 1'b0;
            left_click   <= 1'b0;
            right_click  <= 1'b0;
            middle_click <= 1'b0;
            delta_x      <= 9'd0;
            delta_y      <= 9'd0;
            wheel        <= 4'd0;
            mouse_up     <= 1'b0;
            mouse_down   <= 1'b0;
            mouse_left   <= 1'b0;
            mouse_right  <= 1'b0;
            cursor_x     <= XW'((X_MAX + 1) / 2);
            cursor_y     <= YW'((Y_MAX + 1) / 2);
        end else begin
            packet_valid <= done;
            frame_error  <= err_next;
            if (done) begin
                left_click   <= hdr[0];
                right_click  <= hdr[1];
                middle_click <= hdr[2];
                delta_x      <= dx_new;
                delta_y      <= dy_new;
                wheel        <= wheel_new;
                mouse_right  <= dx_ext > THR;
                mouse_left   <= dx_ext < -THR;
                mouse_up     <= dy_ext > THR;
                mouse_down   <= dy_ext < -THR;
                cursor_x     <= cx_next;
                cursor_y     <= cy_next;
            end
        end
    end

endmodule
